pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry.sv | 28 ++
 rtl/pipe_stage_skid.sv | 126 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline skid stage: state encoding, default
// payload widths and a saturating counter helper.
package pipe_pkg;

    localparam int PIPE_DATA_W = 192;
    localparam int PIPE_CTRL_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry
// One payload storage register with load enable; cleared asynchronously by
// reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - async active-low clear
//   load  - capture d on the next edge
//   d     - incoming entry
//   q     - held entry
module pipe_entry #(
    parameter int W = 196
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic valid/ready pipeline stage. With SKID_EN=1 it holds up to two
// entries (head + skid) so in_ready comes straight from a flop; with
// SKID_EN=0 it is a single register whose in_ready looks through out_ready.
// Payload is opaque: callers concatenate their fields into in_data/in_ctrl.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - upstream handshake
//   in_data/in_ctrl      - upstream payload
//   out_valid/out_ready  - downstream handshake
//   out_data/out_ctrl    - head payload (out_ctrl zeroed when not valid)
//   flush                - synchronous drop of all entries
//   bubble_cnt           - saturating count of cycles with out_valid=0
//
// state | meaning
// EMPTY | no entry held
// FULL  | head entry valid
// SKID  | head and skid entries valid, upstream stalled
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int CTRL_W  = PIPE_CTRL_W,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [15:0]       bubble_cnt
);

    localparam int ENT_W = DATA_W + CTRL_W;

    pipe_state_e       state_q, state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [15:0]       bubble_cnt_q;
    logic              accept;
    logic              take;
    logic              head_load;
    logic              skid_load;
    logic [ENT_W-1:0]  head_d;
    logic [ENT_W-1:0]  head_q;
    logic [ENT_W-1:0]  skid_q;

    // In register mode the stage can refill in the same cycle the head leaves,
    // which needs the combinational look-through of out_ready.
    assign in_ready = (SKID_EN != 0) ? in_ready_q : (!out_valid_q || out_ready);

    // Flush wins over both handshakes.
    assign accept = in_valid && in_ready && !flush;
    assign take   = out_valid_q && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept && !take) begin
                        state_d = (SKID_EN != 0) ? ST_SKID : ST_FULL;
                    end else if (take && !accept) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID:  if (take) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Head refills from the skid entry when draining SKID, otherwise from input.
    assign head_d    = (state_q == ST_SKID) ? skid_q : {in_ctrl, in_data};
    assign head_load = !flush && (((state_q == ST_EMPTY) && accept) ||
                                  ((state_q == ST_FULL)  && accept && take) ||
                                  ((state_q == ST_SKID)  && take));
    assign skid_load = (SKID_EN != 0) && !flush && (state_q == ST_FULL) && accept && !take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_SKID);
            out_valid_q <= (state_d != ST_EMPTY);
            if (!out_valid_q) begin
                bubble_cnt_q <= sat_inc16(bubble_cnt_q);
            end
        end
    end

    pipe_entry #(.W(ENT_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_entry #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = head_q[DATA_W-1:0];
    assign out_ctrl   = out_valid_q ? head_q[ENT_W-1:DATA_W] : '0;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready, flush;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   bubble_cnt;

    logic          in_valid0, out_ready0, flush0;
    logic [DW-1:0] in_data0;
    logic [CW-1:0] in_ctrl0;
    logic          in_ready0, out_valid0;
    logic [DW-1:0] out_data0;
    logic [CW-1:0] out_ctrl0;
    logic [15:0]   bubble_cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+CW-1:0] sb[$];
    logic [15:0]      bc;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          exp_rdy;
        logic          exp_vld;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_ctrl(in_ctrl0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .flush(flush0), .bubble_cnt(bubble_cnt0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; checks at negedge, advances the model at posedge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        logic acc, tk;
        logic [DW+CW-1:0] head;
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
        @(negedge clk);
        chk("in_ready", in_ready, sb.size() < 2);
        chk("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            head = sb[0];
            chk("out_data", out_data, head[DW-1:0]);
            chk("out_ctrl", out_ctrl, head[DW+CW-1:DW]);
        end else begin
            chk("out_ctrl_zero", out_ctrl, 0);
        end
        chk("bubble_cnt", bubble_cnt, bc);
        acc = iv && (sb.size() < 2) && !fl;
        tk  = (sb.size() > 0) && ordy && !fl;
        @(posedge clk);
        if (sb.size() == 0 && bc != 16'hFFFF) bc++;
        if (fl) begin
            sb.delete();
        end else begin
            if (tk) void'(sb.pop_front());
            if (acc) sb.push_back({c, d});
        end
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'hA1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'hA2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 32'hA3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'hA3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'hA3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'hA4, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'hA5, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0; flush = 0;
        in_valid0 = 0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 0; flush0 = 0;
        bc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_bubble0", bubble_cnt0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        bc = 16'd1;
        #1;

        // table vectors
        for (int i = 0; i < 11; i++) begin
            #0;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            #1;
            chk("tbl_in_ready", in_ready, tbl[i].exp_rdy);
            chk("tbl_out_valid", out_valid, tbl[i].exp_vld);
            step(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl);
        end

        // streaming 1..8
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, DW'(k), CW'(k), 1'b1, 1'b0);
            chk("stream_in_ready", in_ready, 1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // flush while in SKID with a simultaneous input and take request
        step(1'b1, 32'hB1, 4'h6, 1'b0, 1'b0);
        step(1'b1, 32'hB2, 4'h7, 1'b0, 1'b0);
        step(1'b1, 32'hB3, 4'h8, 1'b1, 1'b1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_in_ready", in_ready, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // reset pulse between edges while FULL
        step(1'b1, 32'hC1, 4'h9, 1'b0, 1'b0);
        in_valid = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_bubble", bubble_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        sb.delete();
        bc = '0;
        @(posedge clk);
        bc = 16'd1;
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        step(1'b1, 32'hC2, 4'hA, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);

        // register mode (SKID_EN=0)
        in_valid0 = 1; in_data0 = 32'hD1; in_ctrl0 = 4'hB; out_ready0 = 0;
        @(negedge clk);
        chk("r0_in_ready_empty", in_ready0, 1);
        @(posedge clk); #1;
        in_valid0 = 1; in_data0 = 32'hD2; in_ctrl0 = 4'hC;
        @(negedge clk);
        chk("r0_out_valid", out_valid0, 1);
        chk("r0_in_ready_stall", in_ready0, 0);
        chk("r0_out_data", out_data0, 32'hD1);
        @(posedge clk); #1;
        chk("r0_hold_data", out_data0, 32'hD1);
        out_ready0 = 1;
        #1;
        chk("r0_in_ready_comb", in_ready0, 1);
        @(posedge clk); #1;
        in_valid0 = 0;
        @(negedge clk);
        chk("r0_next_data", out_data0, 32'hD2);
        chk("r0_next_ctrl", out_ctrl0, 4'hC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("r0_drained", out_valid0, 0);
        chk("r0_ctrl_zero", out_ctrl0, 0);
        out_ready0 = 0;
        @(posedge clk); #1;

        // bubble counter saturation (main instance idle, out_valid=0)
        for (int n = 0; n < 65540; n++) begin
            @(posedge clk);
            if (bc != 16'hFFFF) bc++;
        end
        #1;
        chk("sat_model", bubble_cnt, bc);
        chk("sat_value", bubble_cnt, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", bubble_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
